// File: rtl/shift_stage_pkg.sv
// Shared constants, op encodings and helpers for the shift stage.
// SHIFT_STAGE_SRL_EN (defined elsewhere) enables the logical right shift for op 10.
package shift_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Left shifts reuse the right-shift barrel on a bit-reversed operand.
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_core.sv
// 5-level logarithmic barrel shifter (16/8/4/2/1) with op-selected fill and direction.
// Op 10 is a logical right shift only when SHIFT_STAGE_SRL_EN is defined.
module shift_core
  import shift_stage_pkg::*;
(
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               err
);

  localparam int LEVELS = SHAMT_W;

  logic              left;
  logic              fill;
  logic [DATA_W-1:0] stg [LEVELS+1];

  always_comb begin
    left = 1'b0;
    fill = 1'b0;
    err  = 1'b0;
    case (op)
      OP_SLL:  left = 1'b1;
      OP_SRA:  fill = data[DATA_W-1];
`ifdef SHIFT_STAGE_SRL_EN
      OP_SRL:  fill = 1'b0;
`endif
      default: err  = 1'b1;
    endcase
  end

  assign stg[0] = left ? bit_rev(data) : data;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int AMT = 1 << (LEVELS - 1 - l);
    assign stg[l+1] = shamt[LEVELS-1-l] ? {{AMT{fill}}, stg[l][DATA_W-1:AMT]} : stg[l];
  end

  assign result = err  ? '0 :
                  left ? bit_rev(stg[LEVELS]) : stg[LEVELS];

endmodule

// File: rtl/shift_stage.sv
// Shift execution stage: barrel shift into a 2-entry in-order result FIFO, 1-cycle latency.
// SHIFT_STAGE_SRL_EN enables op 10 (SRL); otherwise op 10 reports out_err like op 11.
module shift_stage
  import shift_stage_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int DEPTH = 2;

  entry_t            mem [DEPTH];
  entry_t            wr_ent;
  entry_t            head;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] sh_res;
  logic              sh_err;

  shift_core u_core (
    .op     (in_op),
    .data   (in_data),
    .shamt  (in_shamt),
    .result (sh_res),
    .err    (sh_err)
  );

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign wr_ent    = '{tag: in_tag, err: sh_err, data: sh_res};

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  // in_ready looks at the post-edge occupancy only, so it never sees out_ready combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt < 2'd2);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wr_ent;
  end

  // Gate the head with out_valid so a reset or drained FIFO presents all-zero outputs.
  assign head     = out_valid ? mem[rd_ptr] : '0;
  assign out_data = head.data;
  assign out_tag  = head.tag;
  assign out_err  = head.err;

endmodule

// File: tb/tb_shift_stage.sv
// Directed self-checking bench for shift_stage; honours SHIFT_STAGE_SRL_EN for op 10 expectations.
module tb_shift_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  always #5 clock = ~clock;

  shift_stage #(.TAG_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                       input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    in_tag   = tag;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_data = '0; in_shamt = '0; in_tag = '0;
    #1;
    chk_cnt++;
    if ({out_valid, out_data, out_tag, out_err, in_ready} !== 40'h0) begin
      $display("FAIL reset_outputs: got v=%b d=%h t=%h e=%b rdy=%b, want all 0",
               out_valid, out_data, out_tag, out_err, in_ready);
    end else pass_cnt++;
    #1 reset_n = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL ready_after_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_ops();
    vec_t v[$];
    logic [4:0] tag;
    v.push_back('{2'b01, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0});
    v.push_back('{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0});
    v.push_back('{2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0});
    v.push_back('{2'b01, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0});
    v.push_back('{2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780, 1'b0});
    v.push_back('{2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0});
    v.push_back('{2'b00, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b0});
    v.push_back('{2'b01, 32'h8000_F000, 5'd8,  32'hFF80_00F0, 1'b0});
    v.push_back('{2'b00, 32'h0000_ABCD, 5'd3,  32'h0005_5E68, 1'b0});
    v.push_back('{2'b01, 32'h8000_0001, 5'd1,  32'hC000_0000, 1'b0});
    v.push_back('{2'b01, 32'h4000_0000, 5'd5,  32'h0200_0000, 1'b0});
    v.push_back('{2'b11, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 1'b1});
`ifdef SHIFT_STAGE_SRL_EN
    v.push_back('{2'b10, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0});
    v.push_back('{2'b10, 32'hFFFF_FFFF, 5'd4,  32'h0FFF_FFFF, 1'b0});
`else
    v.push_back('{2'b10, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1});
    v.push_back('{2'b10, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 1'b1});
`endif
    foreach (v[i]) begin
      tag = 5'(i + 3);
      out_ready = 1'b0;
      drive(v[i].op, v[i].d, v[i].s, tag);
      tick();
      in_valid = 1'b0;
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== v[i].exp || out_tag !== tag || out_err !== v[i].err)
        $display("FAIL op_vec%0d: got v=%b d=%h t=%0d e=%b want v=1 d=%h t=%0d e=%b", i,
                 out_valid, out_data, out_tag, out_err, v[i].exp, tag, v[i].err);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL op_drain%0d: got v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(2'b00, 32'h1, 5'd1, 5'd1);
    tick();
    drive(2'b00, 32'h1, 5'd2, 5'd2);
    tick();
    chk_cnt++;
    if (in_ready !== 1'b0 || out_data !== 32'h2 || out_tag !== 5'd1)
      $display("FAIL bp_full: got rdy=%b d=%h t=%0d want rdy=0 d=2 t=1", in_ready, out_data, out_tag);
    else pass_cnt++;
    drive(2'b00, 32'h1, 5'd3, 5'd4);
    tick();
    chk_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h2 || out_tag !== 5'd1)
      $display("FAIL bp_hold: got rdy=%b v=%b d=%h t=%0d want rdy=0 v=1 d=2 t=1",
               in_ready, out_valid, out_data, out_tag);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    chk_cnt++;
    if (in_ready !== 1'b1 || out_data !== 32'h4 || out_tag !== 5'd2)
      $display("FAIL bp_pop1: got rdy=%b d=%h t=%0d want rdy=1 d=4 t=2", in_ready, out_data, out_tag);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h8 || out_tag !== 5'd4 || in_ready !== 1'b1)
      $display("FAIL bp_pushpop: got v=%b d=%h t=%0d rdy=%b want v=1 d=8 t=4 rdy=1",
               out_valid, out_data, out_tag, in_ready);
    else pass_cnt++;
    tick();
    out_ready = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got v=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(2'b01, 32'hAAAA_0000, 5'd2, 5'd7);
    tick();
    drive(2'b01, 32'h5555_0000, 5'd2, 5'd8);
    tick();
    drive(2'b00, 32'h0000_00FF, 5'd4, 5'd9);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1)
      $display("FAIL flush_full: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", out_valid, out_data, in_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_nothing_emitted: got v=%b want 0", out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
    drive(2'b00, 32'h1, 5'd0, 5'd10);
    tick();
    drive(2'b00, 32'h1, 5'd5, 5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_push: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    drive(2'b00, 32'h3, 5'd1, 5'd12);
    tick();
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h6 || out_tag !== 5'd12)
      $display("FAIL flush_recover: got v=%b d=%h t=%0d want v=1 d=6 t=12", out_valid, out_data, out_tag);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(2'b01, 32'hF000_000F, 5'd4, 5'd21);
    tick();
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'hFF00_0000 || out_tag !== 5'd21)
      $display("FAIL rst_mid_pre: got v=%b d=%h t=%0d want v=1 d=ff000000 t=21",
               out_valid, out_data, out_tag);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid, out_data, out_tag, out_err, in_ready} !== 40'h0)
      $display("FAIL rst_mid_async: got v=%b d=%h t=%h e=%b rdy=%b want all 0",
               out_valid, out_data, out_tag, out_err, in_ready);
    else pass_cnt++;
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_mid_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 Parameter TAG_W, default 5: width of the destination-register tag carried with each operation.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous discard of all buffered results (pipeline squash).
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 in_op  input  2  operation select: 00 SLL, 01 SRA, 10 SRL, 11 reserved.
REQ-008 in_data  input  32  operand to shift.
REQ-009 in_shamt  input  5  shift amount, 0..31.
REQ-010 in_tag  input  TAG_W  destination tag, passed through unchanged.
REQ-011 out_valid  output  1  head result is present.
REQ-012 out_ready  input  1  downstream consumes the head result this cycle.
REQ-013 out_data  output  32  shifted result.
REQ-014 out_tag  output  TAG_W  tag of the head result.
REQ-015 out_err  output  1  head result came from an unsupported op.

Function
REQ-016 The stage SHALL accept an operation on any rising edge with in_valid and in_ready both high.
REQ-017 The stage SHALL compute the result combinationally from the accepted operands and write it into a 2-entry in-order result FIFO on the accepting edge, giving 1-cycle latency to out_valid.
REQ-018 SLL SHALL fill vacated bits with 0; SRA SHALL fill them with in_data[31]; SRL SHALL fill them with 0; shamt 0 SHALL return in_data unchanged.
REQ-019 Op 11, and op 10 when SRL is compiled out, SHALL produce out_data 0 and out_err 1; every other op SHALL produce out_err 0.
REQ-020 in_ready SHALL be a registered signal, high exactly when the FIFO holds fewer than 2 entries after the current edge, and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be high whenever the FIFO is non-empty; out_data, out_tag and out_err SHALL reflect the oldest entry.
REQ-022 A pop SHALL occur on an edge with out_valid and out_ready both high.
REQ-023 A push and a pop on the same edge with 1 entry held SHALL leave the count at 1, with the new entry at the head.
REQ-024 With 2 entries held, no push SHALL occur (in_ready is low); a pop SHALL return in_ready high on the following cycle.
REQ-025 out_data and out_tag SHALL hold stable while out_valid is high and out_ready is low.
REQ-026 flush SHALL empty the FIFO on its edge, override any simultaneous push or pop, and leave in_ready high on the next cycle.
REQ-027 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear the FIFO, driving out_valid 0, out_data 0, out_tag 0, out_err 0, and in_ready 0.
REQ-029 in_ready SHALL rise on the first rising edge after reset_n deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results without producing a pop.

Configuration
REQ-031 Macro SHIFT_STAGE_SRL_EN: when defined, op 10 SHALL perform a logical right shift.
REQ-032 When SHIFT_STAGE_SRL_EN is not defined, op 10 SHALL be treated as reserved (REQ-019) and no SRL logic SHALL be synthesised.

Structure
REQ-033 A shared package SHALL hold the 2-bit op encodings (OP_SLL, OP_SRA, OP_SRL, OP_RSV) and the data-width constant 32.
REQ-034 The combinational shifter SHALL be a single sub-module, shift_core, implemented as a 5-level logarithmic barrel (16/8/4/2/1) with op-selected fill bit and direction.

Verification
REQ-035 SRA: in_data 0x80000000, shamt 4, tag 3 -> one cycle later out_data 0xF8000000, out_tag 3, out_err 0.
REQ-036 SLL and shamt 0: SLL 0x00000001 by 31 -> 0x80000000; SRA 0x12345678 by 0 -> 0x12345678.
REQ-037 Backpressure: out_ready held 0 while three ops are offered back to back -> two accepted, in_ready low, third held; releasing out_ready drains the results in order and admits the third.
REQ-038 Flush with 2 entries held plus a simultaneous push -> out_valid 0 next cycle, nothing emitted, in_ready 1.
REQ-039 Reserved op 11 (and op 10 without SHIFT_STAGE_SRL_EN) -> out_data 0, out_err 1; op 10 with the macro defined on 0x80000000 by 1 -> 0x40000000.
REQ-040 reset_n pulsed low with 1 entry held -> outputs 0 immediately; in_ready 1 on the first edge after release.
